sr_latch_sequencer: RTL and testbench
=====================================

SR_LATCH_SEQUENCER -- requirements
Module: sr_latch_sequencer

Interface
REQ-001 Parameter N_LATCH, default 8: number of gated SR latches in the controlled bank.
REQ-002 Parameter EN_CYCLES, default 2: enable pulse width in clock cycles; legal range 1..15.
REQ-003 Parameter IW, default 3: index width, equal to clog2(N_LATCH), minimum 1.
REQ-004 clk  in  1  single system clock; all state changes on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req0 / req1  in  1  request from requester 0 / 1; held high until matching gnt.
REQ-007 op0 / op1  in  1  requested operation: 1 = set latch, 0 = clear latch.
REQ-008 idx0 / idx1  in  IW  index of target latch.
REQ-009 gnt0 / gnt1  out  1  one-cycle grant pulse; op/idx captured at the same edge.
REQ-010 busy  out  1  high from grant cycle through done cycle inclusive.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 done_id  out  1  requester served; valid only while done=1.
REQ-013 err  out  1  verify failure or bad index; valid only while done=1.
REQ-014 latch_s / latch_r / latch_en  out  N_LATCH  per-latch set, reset, enable drives to bank.
REQ-015 latch_q  in  N_LATCH  latch Q readback.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 FSM states: IDLE, SETUP, ENABLE, HOLD, CHECK, DONE.
REQ-018 IDLE with any req high at edge k: SHALL go to SETUP at edge k, gnt of winner high for the cycle after edge k, op/idx latched.
REQ-019 Arbitration: single requester wins; both requesting, requester not granted last wins (round-robin); last-grant pointer resets to 1 so req0 wins first tie.
REQ-020 SETUP 1 cycle: s (op=1) or r (op=0) high on selected bit only; en all zero.
REQ-021 ENABLE exactly EN_CYCLES cycles: s/r unchanged, latch_en high on selected bit only.
REQ-022 HOLD 1 cycle: en all zero, s/r still driven.
REQ-023 CHECK 1 cycle: s/r/en all zero; latch_q[idx] sampled at end of cycle; err_next = (sampled q != op).
REQ-024 DONE 1 cycle: done=1, done_id, err driven; then IDLE.
REQ-025 Grant-to-done latency SHALL be EN_CYCLES+3 cycles (grant cycle = 0); minimum req-to-next-grant spacing EN_CYCLES+5 cycles.
REQ-026 Invariant: no bit ever has latch_s and latch_r both high; latch_en never high on a bit without s or r high.
REQ-027 Requests while busy SHALL be ignored, no gnt; still-held requests arbitrated on return to IDLE.
REQ-028 Captured idx >= N_LATCH: SHALL skip SETUP..CHECK, go directly to DONE with err=1, bank drives stay zero.
REQ-029 Request dropped before grant: no grant, no state change.
REQ-030 op/idx changes after grant SHALL not affect the operation in progress.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, all outputs 0, last-grant pointer 1, independent of clk.
REQ-032 Reset mid-operation (any state) SHALL abort without done; latch drives go to 0 immediately.
REQ-033 After rst_n rises, first grant SHALL occur no earlier than first rising edge with rst_n high.

Verification
REQ-034 req0=1, op0=1, idx0=5, bank model correct -> gnt0 cycle 0; latch_s=0x20 cycles 0-3; latch_en=0x20 cycles 1-2; done=1, err=0, done_id=0 at cycle 5.
REQ-035 req0 and req1 high together from reset, held -> gnt0 first, gnt1 next; repeated ties alternate 0,1,0,1.
REQ-036 req1=1, op1=0, idx1=2, latch_q[2] stuck 1 -> latch_r=0x04 pulse sequence, done=1, err=1, done_id=1.
REQ-037 rst_n low during ENABLE -> latch_s, latch_en, busy go 0 asynchronously; no done; next request served normally.
REQ-038 N_LATCH=6, request idx=7 -> gnt, done with err=1 two cycles later, latch_s/r/en remain 0x00.
REQ-039 All scenarios: assertion checks REQ-026 invariant every cycle.

Source files
------------

// File: rtl/sr_latch_sequencer.sv
// Sequencer that drives a bank of gated SR latches on behalf of two requesters.
// Each operation runs SETUP -> ENABLE -> HOLD -> CHECK -> DONE and then reads
// back the latch Q to confirm the write took. Requests are arbitrated
// round-robin. Every output is a flop.
//
// state  | meaning
// IDLE   | waiting for a request; the winner gets its grant at the leaving edge
// SETUP  | s or r asserted on the target bit, enable low
// ENABLE | enable pulse on the target bit for EN_CYCLES cycles
// HOLD   | enable low, s/r still held so data is stable at the gate close
// CHECK  | drives low, Q of the target bit sampled at the end of the cycle
// DONE   | done pulse with requester id and error flag
module sr_latch_sequencer #(
  parameter int N_LATCH   = 8,
  parameter int EN_CYCLES = 2,
  parameter int IW        = (N_LATCH > 1) ? $clog2(N_LATCH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic               req1,
  input  logic               op0,
  input  logic               op1,
  input  logic [IW-1:0]      idx0,
  input  logic [IW-1:0]      idx1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               busy,
  output logic               done,
  output logic               done_id,
  output logic               err,
  output logic [N_LATCH-1:0] latch_s,
  output logic [N_LATCH-1:0] latch_r,
  output logic [N_LATCH-1:0] latch_en,
  input  logic [N_LATCH-1:0] latch_q
);

  typedef enum logic [2:0] {IDLE, SETUP, ENABLE, HOLD, CHECK, DONE} state_t;

  localparam logic [N_LATCH-1:0] ONE = N_LATCH'(1);

  state_t               state;
  logic                 last;
  logic                 op_q;
  logic [IW-1:0]        idx_q;
  logic                 bad_q;
  logic [3:0]           cnt;

  logic                 win_id;
  logic                 win_op;
  logic [IW-1:0]        win_idx;
  logic [N_LATCH-1:0]   win_sel;
  logic [N_LATCH-1:0]   sel_q;
  logic                 q_bit;

  // Winner selection; an out-of-range index shifts the one-hot to all zeros,
  // which doubles as the bad-index flag.
  always_comb begin
    win_id  = req1;
    if (req0 && req1) win_id = ~last;
    win_op  = win_id ? op1 : op0;
    win_idx = win_id ? idx1 : idx0;
    win_sel = ONE << win_idx;
    sel_q   = ONE << idx_q;
    q_bit   = |(latch_q & sel_q);
  end

  // Sequencing FSM; all bank drives and status outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      op_q     <= 1'b0;
      idx_q    <= '0;
      bad_q    <= 1'b0;
      cnt      <= '0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      done_id  <= 1'b0;
      err      <= 1'b0;
      latch_s  <= '0;
      latch_r  <= '0;
      latch_en <= '0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (req0 || req1) begin
            gnt0    <= ~win_id;
            gnt1    <= win_id;
            last    <= win_id;
            op_q    <= win_op;
            idx_q   <= win_idx;
            bad_q   <= (win_sel == '0);
            busy    <= 1'b1;
            latch_s <= win_op ? win_sel : '0;
            latch_r <= win_op ? '0 : win_sel;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (bad_q) begin
            state <= CHECK;
          end else begin
            latch_en <= sel_q;
            cnt      <= 4'(EN_CYCLES - 1);
            state    <= ENABLE;
          end
        end
        ENABLE: begin
          if (cnt == '0) begin
            latch_en <= '0;
            state    <= HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          latch_s <= '0;
          latch_r <= '0;
          state   <= CHECK;
        end
        CHECK: begin
          done    <= 1'b1;
          done_id <= last;
          err     <= bad_q | (q_bit != op_q);
          state   <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// Directed bench for sr_latch_sequencer: an 8-latch instance with a behavioural
// SR bank (with stuck-at-1 injection), and a 6-latch instance for bad indexes.
module tb_sr_latch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       req0, req1, op0, op1;
  logic [2:0] idx0, idx1;
  logic       gnt0, gnt1, busy, done, done_id, err;
  logic [7:0] latch_s, latch_r, latch_en, latch_q;
  logic [7:0] bank = '0;
  logic [7:0] stuck1;
  assign latch_q = bank | stuck1;

  logic       b_req0, b_op0;
  logic [2:0] b_idx0;
  logic       b_gnt0, b_gnt1, b_busy, b_done, b_done_id, b_err;
  logic [5:0] b_s, b_r, b_en;
  logic [5:0] b_q;
  assign b_q = '0;

  int n_cmp = 0;
  int n_err = 0;

  sr_latch_sequencer #(.N_LATCH(8), .EN_CYCLES(2), .IW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1), .idx0(idx0), .idx1(idx1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .done_id(done_id), .err(err),
    .latch_s(latch_s), .latch_r(latch_r), .latch_en(latch_en), .latch_q(latch_q)
  );

  sr_latch_sequencer #(.N_LATCH(6), .EN_CYCLES(2), .IW(3)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .req0(b_req0), .req1(1'b0), .op0(b_op0), .op1(1'b0), .idx0(b_idx0), .idx1(3'd0),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .busy(b_busy), .done(b_done), .done_id(b_done_id), .err(b_err),
    .latch_s(b_s), .latch_r(b_r), .latch_en(b_en), .latch_q(b_q)
  );

  // Behavioural gated SR latch bank
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (latch_en[i]) begin
        if (latch_s[i]) bank[i] <= 1'b1;
        else if (latch_r[i]) bank[i] <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and check the bank-drive invariant on both instances
  task automatic tick();
    @(negedge clk);
    check("inv_sr", 32'(latch_s & latch_r), 32'd0);
    check("inv_en", 32'(latch_en & ~(latch_s | latch_r)), 32'd0);
    check("inv_sr6", 32'(b_s & b_r), 32'd0);
    check("inv_en6", 32'(b_en & ~(b_s | b_r)), 32'd0);
    check("gnt_excl", 32'(gnt0 & gnt1), 32'd0);
  endtask

  task automatic wait_gnt(output int who, output int cyc);
    who = -1;
    cyc = 0;
    for (int i = 0; i < 20 && who < 0; i++) begin
      tick();
      cyc++;
      if (gnt0) who = 0;
      else if (gnt1) who = 1;
    end
  endtask

  // One complete operation from an idle sequencer; cycle 0 is the grant cycle
  task automatic run_op(input bit id, input bit op, input logic [2:0] idx, input bit exp_err);
    logic [7:0] m;
    logic [7:0] e_sr;
    m = 8'h01 << idx;
    tick();
    if (id) begin req1 = 1'b1; op1 = op; idx1 = idx; end
    else    begin req0 = 1'b1; op0 = op; idx0 = idx; end
    for (int c = 0; c <= 6; c++) begin
      tick();
      e_sr = (c <= 3) ? m : 8'h00;
      check("op_s", 32'(latch_s), op ? 32'(e_sr) : 32'd0);
      check("op_r", 32'(latch_r), op ? 32'd0 : 32'(e_sr));
      check("op_en", 32'(latch_en), (c == 1 || c == 2) ? 32'(m) : 32'd0);
      check("op_gnt0", 32'(gnt0), 32'(c == 0 && !id));
      check("op_gnt1", 32'(gnt1), 32'(c == 0 && id));
      check("op_busy", 32'(busy), 32'(c <= 5));
      check("op_done", 32'(done), 32'(c == 5));
      if (c == 5) begin
        check("op_err", 32'(err), 32'(exp_err));
        check("op_done_id", 32'(done_id), 32'(id));
      end
      if (c == 0) begin
        req0 = 1'b0; req1 = 1'b0;
        op0 = ~op; op1 = ~op;
        idx0 = idx + 3'd1; idx1 = idx + 3'd1;
      end
    end
  endtask

  initial begin
    int who, cyc;
    rst_n = 1'b0;
    req0 = 0; req1 = 0; op0 = 0; op1 = 0; idx0 = 0; idx1 = 0;
    b_req0 = 0; b_op0 = 0; b_idx0 = 0;
    stuck1 = 8'h00;

    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
    check("rst_done", 32'({done, done_id, err}), 32'd0);
    check("rst_drv", 32'({latch_s, latch_r, latch_en}), 32'd0);
    check("rst_drv6", 32'({b_s, b_r, b_en, b_busy}), 32'd0);

    // Tie from reset: alternates 0,1,0,1 with 7-cycle grant spacing
    req0 = 1; op0 = 1; idx0 = 3'd1;
    req1 = 1; op1 = 0; idx1 = 3'd1;
    rst_n = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_gnt(who, cyc);
      check("tie_who", 32'(who), 32'(g % 2));
      check("tie_spacing", 32'(cyc), (g == 0) ? 32'd1 : 32'd7);
    end
    req0 = 0; req1 = 0;
    for (int i = 0; i < 8; i++) tick();
    check("tie_idle", 32'(busy), 32'd0);

    // Set latch 5, bank healthy
    run_op(1'b0, 1'b1, 3'd5, 1'b0);
    check("bank5", 32'(bank[5]), 32'd1);

    // Clear latch 2 from requester 1 with Q stuck high
    stuck1 = 8'h04;
    run_op(1'b1, 1'b0, 3'd2, 1'b1);
    stuck1 = 8'h00;

    // Clear latch 5 from requester 1, healthy bank
    run_op(1'b1, 1'b0, 3'd5, 1'b0);
    check("bank5_clr", 32'(bank[5]), 32'd0);

    // Reset during ENABLE aborts immediately, no done
    tick();
    req0 = 1; op0 = 1; idx0 = 3'd4;
    tick();
    check("abort_gnt0", 32'(gnt0), 32'd1);
    req0 = 0;
    tick();
    check("abort_en_pre", 32'(latch_en), 32'h10);
    #2 rst_n = 1'b0;
    #1;
    check("abort_s", 32'(latch_s), 32'd0);
    check("abort_en", 32'(latch_en), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    req0 = 1; op0 = 1; idx0 = 3'd4;
    req1 = 1; op1 = 0; idx1 = 3'd6;
    wait_gnt(who, cyc);
    check("post_rst_who", 32'(who), 32'd0);
    req0 = 0; req1 = 0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check("post_rst_done", 32'(done), 32'(c == 5));
      if (c == 5) begin
        check("post_rst_err", 32'(err), 32'd0);
        check("post_rst_id", 32'(done_id), 32'd0);
      end
    end
    tick();
    check("bank4", 32'(bank[4]), 32'd1);

    // Out-of-range index on the 6-latch instance
    tick();
    b_req0 = 1; b_op0 = 1; b_idx0 = 3'd7;
    for (int c = 0; c <= 3; c++) begin
      tick();
      check("bad_gnt", 32'(b_gnt0), 32'(c == 0));
      check("bad_busy", 32'(b_busy), 32'(c <= 2));
      check("bad_done", 32'(b_done), 32'(c == 2));
      check("bad_drv", 32'({b_s, b_r, b_en}), 32'd0);
      if (c == 2) begin
        check("bad_err", 32'(b_err), 32'd1);
        check("bad_id", 32'(b_done_id), 32'd0);
      end
      if (c == 0) b_req0 = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
